eth_tx_framer: RTL and testbench
================================

# eth_tx_framer

Byte-wide Ethernet transmit framer on `CLK_TX`, directly downstream of the ARP responder's TX byte stream. It accepts a frame as a valid/byte stream with a first-byte acknowledge handshake. It emits preamble and SFD, passes the payload through, optionally zero-pads to the minimum frame size, appends the CRC-32 FCS, and enforces the inter-frame gap. Its output is a GMII-style `TXD`/`TX_EN` pair for the MAC/PHY interface.

## Interface
- `PREAMBLE_LEN`, 7: number of 0x55 bytes before the SFD; minimum 1.
- `MIN_PAYLOAD`, 60: minimum byte count of DA through pad, excluding FCS. Used only when padding is compiled in.
- `IFG_LEN`, 12: idle cycles after the last FCS byte; minimum 1.
- `CLK_TX`  in  1  transmit clock. The block uses this one clock only.
- `ARESET`  in  1  reset; asynchronous, active-high.
- `DATA_VALID_IN`  in  1  upstream frame valid; high for the whole frame, low between frames.
- `DATA_IN`  in  8  upstream frame byte (DA first, MSB-first field order as supplied).
- `DATA_ACK`  out  1  one-cycle pulse; upstream presents first payload byte in the cycle after it.
- `TXD`  out  8  transmit byte, registered.
- `TX_EN`  out  1  transmit enable, registered.
- `TX_BUSY`  out  1  high from frame accept through end of IFG.

## Operation
- States: IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, IFG.
- IDLE: on an edge that samples `DATA_VALID_IN`=1, go to PREAMBLE. Load CRC=0xFFFFFFFF and payload count=0. Set `TX_BUSY`=1, `TX_EN`=1, `TXD`=0x55.
- PREAMBLE: emit `PREAMBLE_LEN` bytes of 0x55, then SFD emits 0xD5 for 1 cycle.
  - `DATA_ACK` is high exactly during the cycle `TXD` carries the last 0x55.
- PAYLOAD: at each edge with `DATA_VALID_IN`=1, set `TXD`<=`DATA_IN`, update CRC, increment count. The count is 11 bits and saturates at 2047.
- The first edge in PAYLOAD with `DATA_VALID_IN`=0 ends the payload.
  - That byte is not transmitted.
  - Go to PAD if padding is enabled and count<`MIN_PAYLOAD`, else go to FCS.
  - A zero-length payload is legal.
- PAD: emit 0x00 bytes, including them in the CRC and count, until count=`MIN_PAYLOAD`.
- FCS: emit ~CRC as 4 bytes, least-significant byte first.
  - CRC is reflected CRC-32: polynomial 0xEDB88320, byte-serial, LSB-first.
- IFG: `TX_EN`=0, `TXD`=0x00 for `IFG_LEN` cycles, then IDLE with `TX_BUSY`=0.
- `DATA_VALID_IN` is ignored outside IDLE and PAYLOAD. A frame that becomes valid during IFG starts in the cycle after IDLE is entered.
- Oversize frames are not truncated.

## Timing
- Reset values: `TXD`=0x00, `TX_EN`=0, `DATA_ACK`=0, `TX_BUSY`=0, state IDLE.
  - Asserting `ARESET` mid-frame forces these values immediately (asynchronously), abandoning the frame. No FCS or IFG is sent.
- Let E0 be the accepting edge:
  - Preamble byte k appears after edge E(k-1).
  - SFD appears after E(`PREAMBLE_LEN`).
  - `DATA_ACK` is high between E(`PREAMBLE_LEN`-1) and E(`PREAMBLE_LEN`).
- Payload latency: a byte on `DATA_IN` during cycle n appears on `TXD` during cycle n+1. No bubbles.
- The FCS follows the last payload or pad byte with no gap.
- `TX_EN` is contiguous from the first preamble byte to the last FCS byte.
- The CRC update and the output register load happen on the same edge. The FCS uses the CRC value after the last payload or pad byte.

## Configuration
- `ETH_TX_PAD_EN` defined: PAD state active; frames shorter than `MIN_PAYLOAD` are zero-padded before the FCS.
- `ETH_TX_PAD_EN` undefined: PAD state and its comparison are absent; the FCS immediately follows the last payload byte regardless of length. `MIN_PAYLOAD` is unused.

## Test plan
- Pad disabled, payload ASCII "123456789" (9 bytes):
  - `TXD` = 55×7, D5, 31..39, then 26 39 F4 CB.
  - `TX_EN` high for 21 cycles, then 12 low; `TX_BUSY` falls after the IFG.
- Pad enabled, 42-byte ARP reply from the upstream responder:
  - `DATA_ACK` pulses once, during the 7th 0x55.
  - 42 bytes pass through unchanged, then 18×0x00, then an FCS matching the reference model.
  - `TX_EN` is high for 72 cycles.
- Pad enabled, zero-length payload (`DATA_VALID_IN` drops in the cycle after `DATA_ACK`): 60×0x00 plus FCS, matching the model.
- Pad enabled, 64-byte payload: no PAD bytes; FCS follows byte 64 directly.
- `DATA_VALID_IN` raised during IFG:
  - The next preamble starts only after 12 idle cycles.
  - The first frame's FCS is unaffected.
- `ARESET` pulsed mid-payload:
  - `TX_EN`, `DATA_ACK` and `TX_BUSY` go low within the same cycle.
  - A subsequent frame is transmitted correctly with a fresh CRC.

Source files
------------

// File: rtl/eth_tx_framer_if.sv
// Byte-stream handshake between the upstream frame source and the TX framer,
// plus the GMII-style transmit outputs and the busy flag.
interface eth_tx_framer_if;
    logic       DATA_VALID_IN;
    logic [7:0] DATA_IN;
    logic       DATA_ACK;
    logic [7:0] TXD;
    logic       TX_EN;
    logic       TX_BUSY;

    modport master (
        output DATA_VALID_IN,
        output DATA_IN,
        input  DATA_ACK,
        input  TXD,
        input  TX_EN,
        input  TX_BUSY
    );

    modport slave (
        input  DATA_VALID_IN,
        input  DATA_IN,
        output DATA_ACK,
        output TXD,
        output TX_EN,
        output TX_BUSY
    );
endinterface

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: preamble/SFD, payload pass-through, CRC-32 FCS and IFG.
// Zero-padding to MIN_PAYLOAD is compiled in when ETH_TX_PAD_EN is defined.
module eth_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
`ifdef ETH_TX_PAD_EN
    parameter int MIN_PAYLOAD  = 60,
`endif
    parameter int IFG_LEN      = 12
) (
    input  logic            CLK_TX,
    input  logic            ARESET,
    eth_tx_framer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_SFD, S_PAYLOAD, S_PAD, S_FCS, S_IFG
    } state_t;

    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN);
    localparam logic [15:0] IFG_LAST = 16'(IFG_LEN);

    state_t      state_reg, state_next;
    logic [7:0]  txd_reg, txd_next;
    logic        tx_en_reg, tx_en_next;
    logic        ack_reg, ack_next;
    logic        busy_reg, busy_next;
    logic [31:0] crc_reg, crc_next;
    logic [15:0] phase_reg, phase_next;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    logic [31:0] crc_data;
    logic [7:0]  fcs_byte;
    logic [31:0] crc_shift;

    assign crc_data  = crc_byte(crc_reg, bus.DATA_IN);
    // During FCS the CRC register doubles as a shift register, low byte out first.
    assign fcs_byte  = ~crc_reg[7:0];
    assign crc_shift = {8'h00, crc_reg[31:8]};

`ifdef ETH_TX_PAD_EN
    localparam logic [10:0] MIN_CNT = 11'(MIN_PAYLOAD);
    logic [10:0] count_reg, count_next;
    logic [10:0] count_inc;
    logic [31:0] crc_zero;

    assign count_inc = (count_reg == 11'h7FF) ? count_reg : count_reg + 11'd1;
    assign crc_zero  = crc_byte(crc_reg, 8'h00);
`endif

    always_ff @(posedge CLK_TX or posedge ARESET) begin
        if (ARESET) begin
            state_reg <= S_IDLE;
            txd_reg   <= 8'h00;
            tx_en_reg <= 1'b0;
            ack_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            crc_reg   <= 32'hFFFFFFFF;
            phase_reg <= 16'd0;
`ifdef ETH_TX_PAD_EN
            count_reg <= 11'd0;
`endif
        end else begin
            state_reg <= state_next;
            txd_reg   <= txd_next;
            tx_en_reg <= tx_en_next;
            ack_reg   <= ack_next;
            busy_reg  <= busy_next;
            crc_reg   <= crc_next;
            phase_reg <= phase_next;
`ifdef ETH_TX_PAD_EN
            count_reg <= count_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        txd_next   = txd_reg;
        tx_en_next = tx_en_reg;
        ack_next   = 1'b0;
        busy_next  = busy_reg;
        crc_next   = crc_reg;
        phase_next = phase_reg;
`ifdef ETH_TX_PAD_EN
        count_next = count_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (bus.DATA_VALID_IN) begin
                    state_next = S_PREAMBLE;
                    txd_next   = 8'h55;
                    tx_en_next = 1'b1;
                    busy_next  = 1'b1;
                    crc_next   = 32'hFFFFFFFF;
                    phase_next = 16'd1;
                    ack_next   = (PRE_LAST == 16'd1);
`ifdef ETH_TX_PAD_EN
                    count_next = 11'd0;
`endif
                end
            end
            S_PREAMBLE: begin
                // phase_reg counts 0x55 bytes already on TXD; ack rides on the last one.
                if (phase_reg < PRE_LAST) begin
                    txd_next   = 8'h55;
                    phase_next = phase_reg + 16'd1;
                    ack_next   = ((phase_reg + 16'd1) == PRE_LAST);
                end else begin
                    txd_next   = 8'hD5;
                    state_next = S_SFD;
                end
            end
            // The byte presented while SFD is on the wire is already payload.
            S_SFD, S_PAYLOAD: begin
                if (bus.DATA_VALID_IN) begin
                    state_next = S_PAYLOAD;
                    txd_next   = bus.DATA_IN;
                    crc_next   = crc_data;
`ifdef ETH_TX_PAD_EN
                    count_next = count_inc;
`endif
                end else begin
`ifdef ETH_TX_PAD_EN
                    if (count_reg < MIN_CNT) begin
                        state_next = S_PAD;
                        txd_next   = 8'h00;
                        crc_next   = crc_zero;
                        count_next = count_inc;
                    end else
`endif
                    begin
                        state_next = S_FCS;
                        txd_next   = fcs_byte;
                        crc_next   = crc_shift;
                        phase_next = 16'd0;
                    end
                end
            end
`ifdef ETH_TX_PAD_EN
            S_PAD: begin
                if (count_reg < MIN_CNT) begin
                    txd_next   = 8'h00;
                    crc_next   = crc_zero;
                    count_next = count_inc;
                end else begin
                    state_next = S_FCS;
                    txd_next   = fcs_byte;
                    crc_next   = crc_shift;
                    phase_next = 16'd0;
                end
            end
`endif
            S_FCS: begin
                if (phase_reg < 16'd3) begin
                    txd_next   = fcs_byte;
                    crc_next   = crc_shift;
                    phase_next = phase_reg + 16'd1;
                end else begin
                    state_next = S_IFG;
                    txd_next   = 8'h00;
                    tx_en_next = 1'b0;
                    phase_next = 16'd1;
                end
            end
            S_IFG: begin
                if (phase_reg < IFG_LAST) begin
                    phase_next = phase_reg + 16'd1;
                end else begin
                    state_next = S_IDLE;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = S_IDLE;
                txd_next   = 8'h00;
                tx_en_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign bus.TXD      = txd_reg;
    assign bus.TX_EN    = tx_en_reg;
    assign bus.DATA_ACK = ack_reg;
    assign bus.TX_BUSY  = busy_reg;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer; expected frames come from a table-driven
// CRC-32 model and hand-computed constants.
module tb_eth_tx_framer;

    localparam int PRE = 7;
`ifdef ETH_TX_PAD_EN
    localparam int PAD_TO = 60;
`else
    localparam int PAD_TO = 0;
`endif

    logic CLK_TX = 1'b0;
    logic ARESET = 1'b1;

    eth_tx_framer_if bus();

    eth_tx_framer dut (
        .CLK_TX (CLK_TX),
        .ARESET (ARESET),
        .bus    (bus)
    );

    always #5 CLK_TX = ~CLK_TX;

    int tests = 0;
    int fails = 0;

    logic [31:0] crc_tab [256];

    byte unsigned cap[$];
    int en_rises   = 0;
    int ack_cnt    = 0;
    int ack_pos    = 0;
    int ifg_cycles = 0;
    int low_run    = 0;
    int last_gap   = 0;
    logic prev_en  = 1'b0;

    // Output monitor, sampled on the falling edge.
    always @(negedge CLK_TX) begin
        if (bus.TX_EN) begin
            cap.push_back(bus.TXD);
            if (!prev_en) begin
                en_rises++;
                last_gap = low_run;
            end
            low_run = 0;
        end else begin
            low_run++;
            if (bus.TX_BUSY) ifg_cycles++;
        end
        if (bus.DATA_ACK) begin
            ack_cnt++;
            ack_pos = cap.size();
        end
        prev_en = bus.TX_EN;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fcs_model(input byte unsigned d[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (d[i]) c = crc_tab[c[7:0] ^ d[i]] ^ (c >> 8);
        return ~c;
    endfunction

    task automatic clear_mon();
        cap.delete();
        en_rises   = 0;
        ack_cnt    = 0;
        ack_pos    = 0;
        ifg_cycles = 0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        do begin
            @(negedge CLK_TX);
            guard++;
        end while (bus.TX_BUSY && guard < 300);
        check("busy_drop", {31'b0, bus.TX_BUSY}, 32'd0);
    endtask

    task automatic wait_ack();
        int guard;
        guard = 0;
        do begin
            @(negedge CLK_TX);
            guard++;
        end while (!bus.DATA_ACK && guard < 100);
        check("ack_seen", {31'b0, bus.DATA_ACK}, 32'd1);
    endtask

    task automatic send_frame(input byte unsigned p[$], input bit wait_done);
        @(negedge CLK_TX);
        bus.DATA_VALID_IN = 1'b1;
        bus.DATA_IN       = 8'h00;
        wait_ack();
        foreach (p[i]) begin
            @(negedge CLK_TX);
            bus.DATA_IN = p[i];
        end
        @(negedge CLK_TX);
        bus.DATA_VALID_IN = 1'b0;
        bus.DATA_IN       = 8'h00;
        if (wait_done) wait_idle();
    endtask

    task automatic check_frame(input string name, input byte unsigned pl[$], input bit full_ifg);
        byte unsigned body[$];
        byte unsigned exp[$];
        logic [31:0] fcs;
        int n;
        body = pl;
        while (body.size() < PAD_TO) body.push_back(8'h00);
        fcs = fcs_model(body);
        for (int i = 0; i < PRE; i++) exp.push_back(8'h55);
        exp.push_back(8'hD5);
        foreach (body[i]) exp.push_back(body[i]);
        for (int i = 0; i < 4; i++) exp.push_back(fcs[8*i +: 8]);
        check({name, ".tx_en_len"}, cap.size(), exp.size());
        n = (cap.size() < exp.size()) ? cap.size() : exp.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s.byte%0d", name, i), {24'h0, cap[i]}, {24'h0, exp[i]});
        check({name, ".tx_en_rises"}, en_rises, 1);
        check({name, ".ack_count"}, ack_cnt, 1);
        check({name, ".ack_pos"}, ack_pos, PRE);
        if (full_ifg) check({name, ".ifg_len"}, ifg_cycles, 12);
    endtask

    task automatic check_fcs_123(input string name);
        int s;
        s = cap.size();
        if (s < 4) begin
            check({name, ".fcs_len"}, s, 21);
        end else begin
            check({name, ".fcs0"}, {24'h0, cap[s-4]}, 32'h26);
            check({name, ".fcs1"}, {24'h0, cap[s-3]}, 32'h39);
            check({name, ".fcs2"}, {24'h0, cap[s-2]}, 32'hF4);
            check({name, ".fcs3"}, {24'h0, cap[s-1]}, 32'hCB);
        end
    endtask

    initial begin
        byte unsigned p123[$];
        byte unsigned arp[$];
        byte unsigned empty[$];
        byte unsigned p64[$];
        byte unsigned p20[$];
        int guard;

        for (int n = 0; n < 256; n++) begin
            logic [31:0] c;
            c = 32'(n);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[n] = c;
        end
        p123 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        arp  = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h02, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h01, 8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04,
                 8'h00, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hC0, 8'hA8,
                 8'h01, 8'h0A, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hC0, 8'hA8,
                 8'h01, 8'h02};
        for (int i = 0; i < 64; i++) p64.push_back(8'(i * 3 + 1));
        for (int i = 0; i < 20; i++) p20.push_back(8'(8'hA0 + i));

        bus.DATA_VALID_IN = 1'b0;
        bus.DATA_IN       = 8'h00;

        // Reset state
        #3;
        check("rst.txd",   {24'h0, bus.TXD},  32'h00);
        check("rst.tx_en", {31'b0, bus.TX_EN}, 32'd0);
        check("rst.ack",   {31'b0, bus.DATA_ACK}, 32'd0);
        check("rst.busy",  {31'b0, bus.TX_BUSY}, 32'd0);
        @(negedge CLK_TX);
        @(negedge CLK_TX);
        ARESET = 1'b0;
        @(negedge CLK_TX);

        // "123456789"
        clear_mon();
        send_frame(p123, 1'b1);
        check_frame("f123", p123, 1'b1);
        check_fcs_123("f123");

        // 42-byte ARP reply
        clear_mon();
        send_frame(arp, 1'b1);
        check_frame("arp42", arp, 1'b1);

        // Zero-length payload
        clear_mon();
        send_frame(empty, 1'b1);
        check_frame("empty", empty, 1'b1);

        // 64-byte payload
        clear_mon();
        send_frame(p64, 1'b1);
        check_frame("p64", p64, 1'b1);

        // Valid raised during IFG of the previous frame
        clear_mon();
        send_frame(p123, 1'b0);
        guard = 0;
        do begin
            @(negedge CLK_TX);
            guard++;
        end while (bus.TX_EN && guard < 200);
        check("ifgA.en_drop", {31'b0, bus.TX_EN}, 32'd0);
        check_fcs_123("ifgA");
        @(negedge CLK_TX);
        @(negedge CLK_TX);
        clear_mon();
        send_frame(arp, 1'b1);
        check_frame("ifgB", arp, 1'b0);
        check("ifgB.gap", last_gap, 13);

        // Reset pulsed mid-payload
        clear_mon();
        @(negedge CLK_TX);
        bus.DATA_VALID_IN = 1'b1;
        wait_ack();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK_TX);
            bus.DATA_IN = p20[i];
        end
        #2 ARESET = 1'b1;
        #1;
        check("rstmid.tx_en", {31'b0, bus.TX_EN}, 32'd0);
        check("rstmid.ack",   {31'b0, bus.DATA_ACK}, 32'd0);
        check("rstmid.busy",  {31'b0, bus.TX_BUSY}, 32'd0);
        check("rstmid.txd",   {24'h0, bus.TXD}, 32'h00);
        @(negedge CLK_TX);
        bus.DATA_VALID_IN = 1'b0;
        bus.DATA_IN       = 8'h00;
        @(negedge CLK_TX);
        ARESET = 1'b0;
        @(negedge CLK_TX);
        clear_mon();
        send_frame(p123, 1'b1);
        check_frame("post_rst", p123, 1'b1);
        check_fcs_123("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
